// File: rtl/pio_pkg.sv
// Shared register map, address type and bus helpers for the Avalon-MM PIO peripheral.
package pio_pkg;

    localparam int unsigned BUS_W = 32;

    typedef logic [2:0] pio_addr_t;

    localparam pio_addr_t ADDR_DATA_IN   = 3'd0;
    localparam pio_addr_t ADDR_DATA_OUT  = 3'd1;
    localparam pio_addr_t ADDR_OUT_SET   = 3'd2;
    localparam pio_addr_t ADDR_OUT_CLR   = 3'd3;
    localparam pio_addr_t ADDR_IRQ_MASK  = 3'd4;
    localparam pio_addr_t ADDR_EDGE_CAP  = 3'd5;
    localparam pio_addr_t ADDR_EDGE_RISE = 3'd6;
    localparam pio_addr_t ADDR_EDGE_FALL = 3'd7;

    // Keep only the low 'width' bits so narrow registers read back zero-extended.
    function automatic logic [BUS_W-1:0] zext32(input logic [BUS_W-1:0] val,
                                               input int unsigned width);
        logic [BUS_W-1:0] mask;
        mask = (width >= BUS_W) ? '1 : ((BUS_W'(1) << width) - BUS_W'(1));
        return val & mask;
    endfunction

endpackage

// File: rtl/pio_debouncer.sv
// Single-bit debouncer: dout follows din only after din has differed from dout
// for DEB_CYCLES consecutive cycles.
module pio_debouncer #(
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;

    // Counter runs only while the input disagrees; any agreement restarts it.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (din != dout_q) begin
            if (cnt_q == CNT_MAX) begin
                dout_d = din;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/avmm_pio_irq.sv
// Avalon-MM PIO with synchronised inputs, per-bit edge capture, atomic set/clear outputs
// and a level IRQ. Define PIO_DEBOUNCE_EN to insert a pio_debouncer on every input bit.
module avmm_pio_irq
    import pio_pkg::*;
#(
    parameter int unsigned          IN_WIDTH   = 10,
    parameter int unsigned          OUT_WIDTH  = 10,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET  = '0,
    parameter int unsigned          DEB_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out,
    output logic                 irq
);

    logic [IN_WIDTH-1:0]  sync1_q, sync2_q, cond_c, cond_d1_q;
    logic [IN_WIDTH-1:0]  mask_q, mask_d, cap_q, cap_d, rise_q, rise_d, fall_q, fall_d;
    logic [IN_WIDTH-1:0]  cap_set_c, w1c_c, wd_in_c;
    logic [OUT_WIDTH-1:0] out_q, out_d, wd_out_c;
    logic [31:0]          rdata_q, rd_val_c;
    logic                 irq_q, irq_d;
    logic                 unused_wd;

    assign unused_wd = ^writedata;
    assign wd_in_c   = writedata[IN_WIDTH-1:0];
    assign wd_out_c  = writedata[OUT_WIDTH-1:0];

`ifdef PIO_DEBOUNCE_EN
    for (genvar i = 0; i < IN_WIDTH; i++) begin : g_deb
        pio_debouncer #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .din  (sync2_q[i]),
            .dout (cond_c[i])
        );
    end
`else
    localparam int unsigned UNUSED_DEB_CYCLES = DEB_CYCLES;
    assign cond_c = sync2_q;
`endif

    assign cap_set_c = (cond_c & ~cond_d1_q & rise_q) | (~cond_c & cond_d1_q & fall_q);

    // Register-file next state; a capture in the same cycle as its W1C wins.
    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        rise_d = rise_q;
        fall_d = fall_q;
        w1c_c  = '0;
        if (write) begin
            case (pio_addr_t'(address))
                ADDR_DATA_OUT:  out_d  = wd_out_c;
                ADDR_OUT_SET:   out_d  = out_q | wd_out_c;
                ADDR_OUT_CLR:   out_d  = out_q & ~wd_out_c;
                ADDR_IRQ_MASK:  mask_d = wd_in_c;
                ADDR_EDGE_CAP:  w1c_c  = wd_in_c;
                ADDR_EDGE_RISE: rise_d = wd_in_c;
                ADDR_EDGE_FALL: fall_d = wd_in_c;
                default: ;
            endcase
        end
        cap_d = (cap_q & ~w1c_c) | cap_set_c;
        irq_d = |(cap_q & mask_q);
    end

    // Read mux samples pre-write state, so read+write returns the old value.
    always_comb begin
        rd_val_c = '0;
        case (pio_addr_t'(address))
            ADDR_DATA_IN:   rd_val_c = zext32(32'(cond_c), IN_WIDTH);
            ADDR_DATA_OUT:  rd_val_c = zext32(32'(out_q), OUT_WIDTH);
            ADDR_IRQ_MASK:  rd_val_c = zext32(32'(mask_q), IN_WIDTH);
            ADDR_EDGE_CAP:  rd_val_c = zext32(32'(cap_q), IN_WIDTH);
            ADDR_EDGE_RISE: rd_val_c = zext32(32'(rise_q), IN_WIDTH);
            ADDR_EDGE_FALL: rd_val_c = zext32(32'(fall_q), IN_WIDTH);
            default:        rd_val_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cond_d1_q <= '0;
            out_q     <= OUT_RESET;
            mask_q    <= '0;
            cap_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            sync1_q   <= pio_in;
            sync2_q   <= sync1_q;
            cond_d1_q <= cond_c;
            out_q     <= out_d;
            mask_q    <= mask_d;
            cap_q     <= cap_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            irq_q     <= irq_d;
            if (read) begin
                rdata_q <= rd_val_c;
            end
        end
    end

    assign readdata = rdata_q;
    assign pio_out  = out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_avmm_pio_irq.sv
// Randomised and directed bench for avmm_pio_irq against a cycle-level behavioural model.
module tb_avmm_pio_irq;
    import pio_pkg::*;

    localparam int unsigned IW  = 10;
    localparam int unsigned OW  = 10;
    localparam int unsigned DEB = 8;
    localparam logic [9:0]  ORST = 10'h155;
`ifdef PIO_DEBOUNCE_EN
    localparam int unsigned LAT = DEB + 2;
    localparam bit          USE_DEB = 1'b1;
`else
    localparam int unsigned LAT = 2;
    localparam bit          USE_DEB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [9:0]  pio_in = '0;
    logic [9:0]  pio_out;
    logic        irq;

    always #5 clk = ~clk;

    avmm_pio_irq #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .OUT_RESET (ORST),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .read     (read),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .pio_in   (pio_in),
        .pio_out  (pio_out),
        .irq      (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: registers as plain words, input path as a 2-deep delay line
    // followed by an optional "held-for-DEB-cycles" filter.
    logic [9:0]  m_out, m_mask, m_cap, m_rise, m_fall, m_dcond, m_prev;
    logic [31:0] m_rdata;
    logic        m_irq;
    logic [9:0]  m_dly[$];
    int          m_run[10];
    bit          m_rd_seen;

    function automatic logic [31:0] m_reg(input logic [2:0] a, input logic [9:0] c);
        case (a)
            3'd0:    return {22'd0, c};
            3'd1:    return {22'd0, m_out};
            3'd4:    return {22'd0, m_mask};
            3'd5:    return {22'd0, m_cap};
            3'd6:    return {22'd0, m_rise};
            3'd7:    return {22'd0, m_fall};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [9:0] sync_pre, cond_pre, set, wd;
        m_rd_seen = 1'b0;
        if (reset) begin
            m_out = ORST; m_mask = '0; m_cap = '0; m_rise = '0; m_fall = '0;
            m_dcond = '0; m_prev = '0; m_rdata = '0; m_irq = 1'b0;
            m_dly = '{10'd0, 10'd0};
            for (int b = 0; b < 10; b++) m_run[b] = 0;
            return;
        end
        sync_pre = m_dly[0];
        cond_pre = USE_DEB ? m_dcond : sync_pre;
        set = (cond_pre & ~m_prev & m_rise) | (~cond_pre & m_prev & m_fall);
        if (read) begin
            m_rdata = m_reg(address, cond_pre);
            m_rd_seen = 1'b1;
        end
        m_irq = |(m_cap & m_mask);
        wd = writedata[9:0];
        if (write) begin
            case (address)
                3'd1: m_out  = wd;
                3'd2: m_out  = m_out | wd;
                3'd3: m_out  = m_out & ~wd;
                3'd4: m_mask = wd;
                3'd5: m_cap  = m_cap & ~wd;
                3'd6: m_rise = wd;
                3'd7: m_fall = wd;
                default: ;
            endcase
        end
        m_cap  = m_cap | set;
        m_prev = cond_pre;
        for (int b = 0; b < 10; b++) begin
            if (sync_pre[b] != m_dcond[b]) begin
                m_run[b]++;
                if (m_run[b] == int'(DEB)) begin
                    m_dcond[b] = sync_pre[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        void'(m_dly.pop_front());
        m_dly.push_back(pio_in);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pio_out", 32'(pio_out), 32'(m_out));
        check("irq", 32'(irq), 32'(m_irq));
        if (m_rd_seen) check("readdata", readdata, m_rdata);
    endtask

    task automatic bus(input logic [2:0] a, input logic r, input logic w, input logic [31:0] d);
        address = a; read = r; write = w; writedata = d;
        tick();
        read = 1'b0; write = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus(a, 1'b1, 1'b0, 32'd0);
        check(tag, readdata, exp);
    endtask

    initial begin
        // Reset values
        reset = 1'b1;
        repeat (3) tick();
        check("rst_pio_out", 32'(pio_out), 32'h155);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_pio_out", 32'(pio_out), 32'h155);
        check("post_rst_irq", 32'(irq), 32'd0);
        rd_expect("rst_data_in", ADDR_DATA_IN, 32'd0);

        // Output write / set / clear
        bus(ADDR_DATA_OUT, 1'b0, 1'b1, 32'h0F0);
        check("out_write", 32'(pio_out), 32'h0F0);
        bus(ADDR_OUT_SET, 1'b0, 1'b1, 32'h00F);
        check("out_set", 32'(pio_out), 32'h0FF);
        bus(ADDR_OUT_CLR, 1'b0, 1'b1, 32'h030);
        check("out_clr", 32'(pio_out), 32'h0CF);
        rd_expect("rd_data_out", ADDR_DATA_OUT, 32'h0CF);
        rd_expect("rd_out_set_wo", ADDR_OUT_SET, 32'd0);

        // Rising edge capture and IRQ on bit 0
        bus(ADDR_EDGE_RISE, 1'b0, 1'b1, 32'h001);
        bus(ADDR_IRQ_MASK, 1'b0, 1'b1, 32'h001);
        pio_in = 10'h001;
        repeat (LAT) tick();
        tick();
        check("edge_irq_early", 32'(irq), 32'd0);
        tick();
        check("edge_irq", 32'(irq), 32'd1);
        rd_expect("edge_cap", ADDR_EDGE_CAP, 32'h001);
        bus(ADDR_EDGE_CAP, 1'b0, 1'b1, 32'h001);
        check("w1c_irq_hold", 32'(irq), 32'd1);
        tick();
        check("w1c_irq_drop", 32'(irq), 32'd0);
        pio_in = 10'h000;
        repeat (LAT + 2) tick();
        check("fall_no_irq", 32'(irq), 32'd0);
        rd_expect("fall_no_cap", ADDR_EDGE_CAP, 32'd0);

        // Capture on bit 2 coinciding with its W1C
        bus(ADDR_EDGE_RISE, 1'b0, 1'b1, 32'h004);
        bus(ADDR_IRQ_MASK, 1'b0, 1'b1, 32'h004);
        pio_in = 10'h004;
        repeat (LAT + 2) tick();
        check("b2_irq", 32'(irq), 32'd1);
        pio_in = 10'h000;
        repeat (LAT + 2) tick();
        pio_in = 10'h004;
        repeat (LAT) tick();
        bus(ADDR_EDGE_CAP, 1'b0, 1'b1, 32'h004);
        check("coll_irq0", 32'(irq), 32'd1);
        tick();
        check("coll_irq1", 32'(irq), 32'd1);
        rd_expect("coll_cap", ADDR_EDGE_CAP, 32'h004);
        bus(ADDR_EDGE_CAP, 1'b0, 1'b1, 32'h3FF);
        bus(ADDR_IRQ_MASK, 1'b0, 1'b1, 32'h000);
        pio_in = 10'h000;
        repeat (LAT + 2) tick();
        bus(ADDR_EDGE_CAP, 1'b0, 1'b1, 32'h3FF);

`ifdef PIO_DEBOUNCE_EN
        // Debounce: short glitch ignored, long pulse lands exactly LAT cycles later
        bus(ADDR_EDGE_RISE, 1'b0, 1'b1, 32'h008);
        pio_in = 10'h008;
        repeat (5) tick();
        pio_in = 10'h000;
        repeat (20) tick();
        rd_expect("deb_glitch_in", ADDR_DATA_IN, 32'd0);
        rd_expect("deb_glitch_cap", ADDR_EDGE_CAP, 32'd0);
        pio_in = 10'h008;
        repeat (LAT - 1) tick();
        rd_expect("deb_before", ADDR_DATA_IN, 32'd0);
        rd_expect("deb_after", ADDR_DATA_IN, 32'h008);
        repeat (9) tick();
        pio_in = 10'h000;
        repeat (LAT + 2) tick();
        bus(ADDR_EDGE_CAP, 1'b0, 1'b1, 32'h3FF);
`endif

        // Reset in the middle of activity
        bus(ADDR_EDGE_RISE, 1'b0, 1'b1, 32'h3FF);
        bus(ADDR_IRQ_MASK, 1'b0, 1'b1, 32'h3FF);
        pio_in = 10'h3FF;
        repeat (LAT + 2) tick();
        check("mid_irq", 32'(irq), 32'd1);
        rd_expect("mid_cap", ADDR_EDGE_CAP, 32'h3FF);
        reset = 1'b1;
        tick();
        check("mid_rst_irq", 32'(irq), 32'd0);
        check("mid_rst_out", 32'(pio_out), 32'h155);
        reset = 1'b0;
        rd_expect("mid_rst_cap", ADDR_EDGE_CAP, 32'd0);
        repeat (LAT + 3) tick();
        check("no_spur_irq", 32'(irq), 32'd0);
        rd_expect("no_spur_cap", ADDR_EDGE_CAP, 32'd0);
        rd_expect("held_in", ADDR_DATA_IN, 32'h3FF);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 15) == 0) pio_in = pio_in ^ (10'd1 << $urandom_range(0, 9));
            bus(3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), $urandom);
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
